uart_cmd_responder: RTL



---
 rtl/uart_cmd_responder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_responder.sv
// Opcode-driven responder: snapshots channel values on command acceptance and
// streams framed, checksummed responses byte by byte through the UART TX handshake.
module uart_cmd_responder #(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_W   = 10,
    parameter int TX_TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         reset_b,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_ready,
    input  logic [NUM_CH*SAMPLE_W-1:0]   ch_data,
    input  logic                         tx_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_write_en,
    output logic                         clear_max,
    output logic                         busy,
    output logic                         cmd_dropped
);

    localparam int B  = (SAMPLE_W + 7) / 8;
    localparam int VW = 8 * B;
    localparam int PW = NUM_CH * VW;
    localparam int CW = $clog2(NUM_CH * B + 3);
    localparam int TW = $clog2(TX_TIMEOUT + 1);

    localparam logic [7:0]    HDR       = 8'hA5;
    localparam logic [7:0]    ACK       = 8'h06;
    localparam logic [7:0]    NAK       = 8'h15;
    localparam logic [7:0]    OP_BURST  = 8'h20;
    localparam logic [7:0]    OP_CLEAR  = 8'h30;
    localparam logic [4:0]    NCH       = NUM_CH[4:0];
    localparam logic [CW-1:0] LEN_READ  = CW'(B + 2);
    localparam logic [CW-1:0] LEN_BURST = CW'(NUM_CH * B + 2);
    localparam logic [CW-1:0] LEN_ONE   = CW'(1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TX_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [PW-1:0]    payload;
    logic [PW-1:0]    burst_img;
    logic [PW-1:0]    read_img;
    logic [CW-1:0]    idx;
    logic [CW-1:0]    len;
    logic [7:0]       cur_byte;
    logic [7:0]       tx_hold;
    logic [7:0]       csum;
    logic [TW-1:0]    tmo;
    logic [3:0]       rd_ch;
    logic             op_read;
    logic             op_burst;
    logic             op_clear;
    logic             last_byte;
    logic             accept;

    function automatic logic [VW-1:0] ext(input logic [SAMPLE_W-1:0] s);
        logic [VW-1:0] v;
        v = '0;
        v[SAMPLE_W-1:0] = s;
        return v;
    endfunction

    always_comb begin
        rd_ch    = rx_data[3:0];
        op_read  = (rx_data[7:4] == 4'h1) && ({1'b0, rd_ch} < NCH);
        op_burst = (rx_data == OP_BURST);
        op_clear = (rx_data == OP_CLEAR);
    end

    // Payload images are laid out MSB-first so the frame is emitted by shifting left.
    always_comb begin
        burst_img = '0;
        read_img  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            burst_img[PW-1-k*VW -: VW] = ext(ch_data[k*SAMPLE_W +: SAMPLE_W]);
            if (k == 32'(rd_ch)) begin
                read_img[PW-1 -: VW] = ext(ch_data[k*SAMPLE_W +: SAMPLE_W]);
            end
        end
    end

    // The last WAIT_DONE cycle of a frame behaves as IDLE for an arriving command.
    always_comb begin
        last_byte = (idx == len - 1'b1);
        accept    = rx_ready && ((state == IDLE) ||
                                 ((state == WAIT_DONE) && tx_ready && last_byte));
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (accept) state_nx = SEND;
            SEND:      if (tx_ready && !clear_max) state_nx = WAIT_BUSY;
            WAIT_BUSY: if (!tx_ready || (tmo == TMO_LAST)) state_nx = WAIT_DONE;
            WAIT_DONE: if (tx_ready) state_nx = (!last_byte || accept) ? SEND : IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Write is held off while clear_max is high so ACK follows the clear pulse.
    always_comb begin
        tx_write_en = (state == SEND) && tx_ready && !clear_max;
        tx_data     = tx_write_en ? cur_byte : tx_hold;
        busy        = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            payload     <= '0;
            idx         <= '0;
            len         <= '0;
            cur_byte    <= '0;
            tx_hold     <= '0;
            csum        <= '0;
            tmo         <= '0;
            clear_max   <= 1'b0;
            cmd_dropped <= 1'b0;
        end else begin
            clear_max   <= 1'b0;
            cmd_dropped <= rx_ready && !accept;
            if (tx_write_en) begin
                tx_hold <= cur_byte;
            end
            if (state == WAIT_BUSY) begin
                tmo <= tmo + 1'b1;
            end else begin
                tmo <= '0;
            end
            if (accept) begin
                idx     <= '0;
                csum    <= '0;
                payload <= op_burst ? burst_img : read_img;
                if (op_read) begin
                    len      <= LEN_READ;
                    cur_byte <= HDR;
                end else if (op_burst) begin
                    len      <= LEN_BURST;
                    cur_byte <= HDR;
                end else if (op_clear) begin
                    len       <= LEN_ONE;
                    cur_byte  <= ACK;
                    clear_max <= 1'b1;
                end else begin
                    len      <= LEN_ONE;
                    cur_byte <= NAK;
                end
            end else if ((state == WAIT_DONE) && tx_ready && !last_byte) begin
                idx <= idx + 1'b1;
                if ((idx + 1'b1) == (len - 1'b1)) begin
                    cur_byte <= csum;
                end else begin
                    cur_byte <= payload[PW-1 -: 8];
                    payload  <= payload << 8;
                    csum     <= csum + payload[PW-1 -: 8];
                end
            end
        end
    end

endmodule
